// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage rv32i pipeline.
// Drives the PC and stage-register load enables, inserts load-use bubbles,
// flushes on EX redirects and owns the imem/dmem request handshakes,
// buffering whichever memory response arrives first.
// Optional feature macro: PIPE_CTRL_PERF_EN adds four 32-bit performance
// counters (perf_cycles, perf_mem_stall, perf_lu_bubble, perf_redirect).
module pipe_ctrl #(
    parameter int STALL_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic [31:0] fetch_ir,
    input  logic        mem_is_load,
    input  logic        mem_is_store,
    output logic        dmem_read,
    output logic        dmem_write,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_rdata,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        pc_redirect,
    output logic        mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_mem_stall,
    output logic [31:0] perf_lu_bubble,
    output logic [31:0] perf_redirect
`endif
);

    // Watchdog counter only needs to reach STALL_TIMEOUT, then it saturates.
    localparam int CW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LIMIT = CW'(STALL_TIMEOUT);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           i_done_q, i_done_d;
    logic           d_done_q, d_done_d;
    logic [31:0]    ibuf_q, ibuf_d;
    logic [31:0]    dbuf_q, dbuf_d;
    logic [CW-1:0]  wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;

    logic           run;
    logic           mem_op;
    logic           i_ok;
    logic           d_ok;
    logic           advance;
    logic           load_use;

    // Reset is also gated in here so requests drop in the very cycle rst falls.
    assign run      = rst & (state_q == RUN);
    assign mem_op   = mem_is_load | mem_is_store;
    assign i_ok     = imem_resp | i_done_q;
    assign d_ok     = ~mem_op | dmem_resp | d_done_q;
    assign advance  = run & i_ok & d_ok;

    // Load-use hazard: EX load writes a register the ID instruction reads (x0 never hazards).
    assign load_use = ex_is_load & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Buffered response wins over the live bus once captured.
    assign fetch_ir    = i_done_q ? ibuf_q : imem_rdata;
    assign mem_rdata   = d_done_q ? dbuf_q : dmem_rdata;
    assign mem_timeout = timeout_q;

    // State register: reset parks the sequencer in BOOT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BOOT lasts a single cycle, RUN holds until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Outputs: requests while running, stage enables only on advance, by priority.
    always_comb begin
        imem_read   = 1'b0;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        pc_redirect = 1'b0;
        if (run) begin
            imem_read  = ~i_done_q;
            dmem_read  = mem_is_load & ~d_done_q;
            dmem_write = mem_is_store & ~d_done_q;
        end
        if (advance) begin
            if (ex_redirect) begin
                // ID instruction is squashed, so any load-use hazard is moot.
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                pc_redirect = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID (same PC is refetched), bubble into ID/EX.
                load_id_ex  = 1'b1;
                flush_id_ex = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end
        end
    end

    // Next values for response buffers and the stall watchdog.
    always_comb begin
        i_done_d  = i_done_q;
        d_done_d  = d_done_q;
        ibuf_d    = ibuf_q;
        dbuf_d    = dbuf_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (advance) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
            wd_cnt_d = '0;
        end else if (run) begin
            // Capture only the first response of each side; late or unrequested ones drop.
            if (imem_resp && !i_done_q) begin
                ibuf_d   = imem_rdata;
                i_done_d = 1'b1;
            end
            if (dmem_resp && !d_done_q && mem_op) begin
                dbuf_d   = dmem_rdata;
                d_done_d = 1'b1;
            end
            if (STALL_TIMEOUT != 0) begin
                if (wd_cnt_q != WD_LIMIT) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                if (wd_cnt_d == WD_LIMIT) begin
                    timeout_d = 1'b1;
                end
            end
        end
    end

    // Response buffers and watchdog registers; timeout is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            ibuf_q    <= '0;
            dbuf_q    <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            ibuf_q    <= ibuf_d;
            dbuf_q    <= dbuf_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_mem_stall_q;
    logic [31:0] perf_lu_bubble_q;
    logic [31:0] perf_redirect_q;

    assign perf_cycles    = perf_cycles_q;
    assign perf_mem_stall = perf_mem_stall_q;
    assign perf_lu_bubble = perf_lu_bubble_q;
    assign perf_redirect  = perf_redirect_q;

    // Free-running wrap-around event counters for RUN cycles, stalls, bubbles, redirects.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cycles_q    <= '0;
            perf_mem_stall_q <= '0;
            perf_lu_bubble_q <= '0;
            perf_redirect_q  <= '0;
        end else if (run) begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if (!advance) begin
                perf_mem_stall_q <= perf_mem_stall_q + 32'd1;
            end else if (ex_redirect) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end else if (load_use) begin
                perf_lu_bubble_q <= perf_lu_bubble_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage rv32i pipeline.
- Drives the load enable of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Inserts bubbles for load-use hazards and flushes on EX redirects.
- Owns the imem/dmem request handshakes, buffering whichever memory response arrives first while the other is still outstanding.

Parameters:
STALL_TIMEOUT, 1023, consecutive non-advancing cycles before mem_timeout sets; 0 disables the watchdog.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low (rst==0 resets)
imem_read  out  1  instruction fetch request
imem_resp  in  1  fetch data valid, single-cycle pulse
imem_rdata  in  32  fetch data
fetch_ir  out  32  instruction to IF/ID ir_i
mem_is_load  in  1  MEM-stage instruction is a load
mem_is_store  in  1  MEM-stage instruction is a store
dmem_read  out  1  data read request
dmem_write  out  1  data write request
dmem_resp  in  1  data access complete, single-cycle pulse
dmem_rdata  in  32  load data
mem_rdata  out  32  load data to MEM/WB
id_rs1, id_rs2  in  5 each  ID-stage source registers
id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2
ex_is_load  in  1  EX-stage instruction is a load
ex_rd  in  5  EX-stage destination register
ex_redirect  in  1  EX resolved taken branch/jump
load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage load enables
flush_if_id, flush_id_ex  out  1 each  load a bubble (NOP) instead of data
pc_redirect  out  1  PC mux selects EX target
mem_timeout  out  1  sticky watchdog flag

Behaviour:
- State BOOT/RUN.
  - rst==0 forces BOOT and clears i_done, d_done, ibuf, dbuf, watchdog count and mem_timeout.
  - BOOT lasts exactly one cycle after rst returns to 1, then RUN.
  - In BOOT, and while rst==0, all load_*, flush_*, imem_read, dmem_read, dmem_write and pc_redirect are 0.
- Requests in RUN (held until serviced):
  - imem_read = !i_done.
  - dmem_read = mem_is_load & !d_done.
  - dmem_write = mem_is_store & !d_done.
- Completion terms:
  - i_ok = imem_resp | i_done.
  - d_ok = !(mem_is_load | mem_is_store) | dmem_resp | d_done.
  - advance = RUN & i_ok & d_ok.
- Not advancing:
  - All load_* and flush_* are 0.
  - If imem_resp & !i_done: ibuf <= imem_rdata, i_done <= 1.
  - If dmem_resp & !d_done & (load|store): dbuf <= dmem_rdata, d_done <= 1.
  - Responses arriving when already done, or not requested, are ignored.
- Data mux (combinational):
  - fetch_ir = i_done ? ibuf : imem_rdata.
  - mem_rdata = d_done ? dbuf : dmem_rdata.
- On advance, i_done and d_done clear next cycle. Outputs by priority:
  1. ex_redirect: all five loads = 1, pc_redirect = 1, flush_if_id = 1, flush_id_ex = 1. Load-use is ignored because the ID instruction is squashed.
  2. Load-use: load_use = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
     - load_pc = 0, load_if_id = 0.
     - load_id_ex = 1 with flush_id_ex = 1 (bubble).
     - load_ex_mem = 1, load_mem_wb = 1.
     - The fetched word is discarded; the same PC is refetched.
  3. Otherwise: all five loads = 1, no flush, pc_redirect = 0.
- Simultaneous imem_resp and dmem_resp in the same cycle with both outstanding: advance immediately, no buffering.
- Watchdog:
  - Counter increments on each RUN cycle with !advance and clears on advance.
  - Saturates at STALL_TIMEOUT; on reaching it, mem_timeout = 1 until reset.
  - The pipeline continues to wait normally after mem_timeout sets.
- Reset mid-stall: outstanding requests drop immediately; late responses arriving in BOOT are ignored.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN. When defined, add four 32-bit outputs, all reset to 0, wrapping modulo 2^32:
  - perf_cycles: RUN cycles.
  - perf_mem_stall: RUN cycles with !advance.
  - perf_lu_bubble: advances taking the load-use path.
  - perf_redirect: advances with ex_redirect.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then release; imem_resp every cycle, no memory ops -> cycle 1 after release all 0; from cycle 2 imem_read=1 and all loads=1 each cycle.
- imem_resp at cycle 2 with rdata=0x00A00093; mem_is_load=1, dmem_resp at cycle 5 with rdata=0xDEADBEEF -> i_done set, fetch_ir=0x00A00093 held on cycles 3-5, imem_read=0 on cycles 3-5; advance at cycle 5 with mem_rdata=0xDEADBEEF; i_done/d_done clear cycle 6.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, responses ready -> load_pc=0, load_if_id=0, flush_id_ex=1, load_id_ex/load_ex_mem/load_mem_wb=1; same case with ex_rd=0 -> normal advance.
- ex_redirect=1 together with the load-use condition and a 3-cycle imem wait -> nothing loads until imem_resp; then all loads=1, pc_redirect=1, flush_if_id=1, flush_id_ex=1.
- STALL_TIMEOUT=4, imem_resp never asserted -> mem_timeout rises after the 4th stalled RUN cycle and stays high after a later imem_resp; only rst==0 clears it.
- Assert rst=0 while d_done=1 and dmem outstanding -> next cycle dmem_read=0; a dmem_resp during BOOT is ignored; a normal fetch resumes afterwards.
